fixed_multiply: RTL and testbench

//   Iterative unsigned fixed-point multiplier, the inverse of fixed_divide.

---
 rtl/fixed_pkg.sv | 24 ++
 rtl/fixed_multiply_if.sv | 38 +++
 rtl/fixed_multiply.sv | 97 +++++++++
 tb/tb_fixed_multiply.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the divider/multiplier pair.
package fixed_pkg;

    localparam int unsigned INT_W  = 24;
    localparam int unsigned Q_W    = 26;
    localparam int unsigned FRAC_W = 25;
    localparam int unsigned ACC_W  = INT_W + Q_W;
    localparam int unsigned CNT_W  = $clog2(Q_W);

    typedef logic [INT_W-1:0] fixed_int_t;
    typedef logic [Q_W-1:0]   fixed_q_t;
    typedef logic [ACC_W-1:0] fixed_acc_t;

    // Drop the fraction bits and saturate; returns {overflow, product}.
    function automatic logic [INT_W:0] saturate(input fixed_acc_t acc);
        logic [INT_W:0] int_part;
        int_part = acc[ACC_W-1:FRAC_W];
        if (int_part[INT_W]) begin
            return {1'b1, {INT_W{1'b1}}};
        end
        return {1'b0, int_part[INT_W-1:0]};
    endfunction

endpackage

// File: rtl/fixed_multiply_if.sv
// Operand/result handshake bundle for fixed_multiply.
interface fixed_multiply_if;
    import fixed_pkg::*;

    logic       valid_in;
    logic       ready_out;
    fixed_int_t operand_in;
    fixed_q_t   factor_in;
    logic       valid_out;
    logic       ready_in;
    logic       overflow_out;
    fixed_int_t product_out;

    // Multiplier side.
    modport slave (
        input  valid_in,
        input  operand_in,
        input  factor_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output overflow_out,
        output product_out
    );

    // Requester side.
    modport master (
        output valid_in,
        output operand_in,
        output factor_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  overflow_out,
        input  product_out
    );

endinterface

// File: rtl/fixed_multiply.sv
// Iterative unsigned multiplier: integer x Q1.25 factor, one factor bit per cycle,
// MSB first, with a saturated integer result.
module fixed_multiply
    import fixed_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    fixed_multiply_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    fixed_int_t       operand_q, operand_d;
    fixed_q_t         factor_q, factor_d;
    fixed_acc_t       acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    fixed_int_t       product_q, product_d;

    fixed_acc_t       acc_next;
    logic [INT_W:0]   sat_res;

    // Next-state, shift-add datapath and result capture.
    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        factor_d   = factor_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        product_d  = product_q;

        acc_next = {acc_q[ACC_W-2:0], 1'b0} +
                   (factor_q[count_q] ? fixed_acc_t'(operand_q) : fixed_acc_t'(0));
        sat_res  = saturate(acc_next);

        case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    operand_d = bus.operand_in;
                    factor_d  = bus.factor_in;
                    acc_d     = '0;
                    count_d   = CNT_W'(Q_W - 1);
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                acc_d = acc_next;
                if (count_q == '0) begin
                    // Last bit: results are registered on the same edge as entering DONE.
                    overflow_d = sat_res[INT_W];
                    product_d  = sat_res[INT_W-1:0];
                    state_d    = StDone;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            StDone: begin
                if (bus.ready_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            operand_q  <= '0;
            factor_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            factor_q   <= factor_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            product_q  <= product_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        bus.ready_out    = (state_q == StIdle);
        bus.valid_out    = (state_q == StDone);
        bus.overflow_out = overflow_q;
        bus.product_out  = product_q;
    end

endmodule

// File: tb/tb_fixed_multiply.sv
// Directed and round-trip checks for fixed_multiply.
module tb_fixed_multiply;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fixed_multiply_if bus_if ();

    fixed_multiply dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [23:0] a, input logic [25:0] f);
        check("accept_ready", {63'd0, bus_if.ready_out}, 64'd1);
        bus_if.operand_in = a;
        bus_if.factor_in  = f;
        bus_if.valid_in   = 1'b1;
        @(negedge clk);
        bus_if.valid_in   = 1'b0;
    endtask

    // Counts edges after the accept edge until valid_out is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus_if.valid_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_timeout", {63'd0, bus_if.valid_out}, 64'd1);
    endtask

    task automatic finish_op();
        bus_if.ready_in = 1'b1;
        @(negedge clk);
        bus_if.ready_in = 1'b0;
        check("valid_drop", {63'd0, bus_if.valid_out}, 64'd0);
        check("ready_back", {63'd0, bus_if.ready_out}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [23:0] a, input logic [25:0] f,
                          input logic [23:0] exp_p, input logic exp_o);
        int lat;
        start_op(a, f);
        wait_done(lat);
        check({tag, "_product"}, 64'(bus_if.product_out), 64'(exp_p));
        check({tag, "_overflow"}, {63'd0, bus_if.overflow_out}, {63'd0, exp_o});
        finish_op();
    endtask

    initial begin
        int          lat;
        logic [23:0] held;
        logic [63:0] a, b, q, model, lo;

        bus_if.valid_in   = 1'b0;
        bus_if.ready_in   = 1'b0;
        bus_if.operand_in = '0;
        bus_if.factor_in  = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, bus_if.ready_out}, 64'd1);
        check("rst_valid", {63'd0, bus_if.valid_out}, 64'd0);
        check("rst_ovf", {63'd0, bus_if.overflow_out}, 64'd0);
        check("rst_prod", 64'(bus_if.product_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 1000 x 0.5 with latency.
        start_op(24'd1000, 26'h1000000);
        wait_done(lat);
        check("t1_latency", 64'(lat), 64'd26);
        check("t1_product", 64'(bus_if.product_out), 64'd500);
        check("t1_overflow", {63'd0, bus_if.overflow_out}, 64'd0);
        finish_op();

        // 2: x1.0 with ready_in held high throughout (no effect outside DONE).
        bus_if.ready_in = 1'b1;
        start_op(24'hFFFFFF, 26'h2000000);
        lat = 0;
        while (!bus_if.valid_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t2_latency", 64'(lat), 64'd26);
        check("t2_product", 64'(bus_if.product_out), 64'hFFFFFF);
        check("t2_overflow", {63'd0, bus_if.overflow_out}, 64'd0);
        @(negedge clk);
        bus_if.ready_in = 1'b0;
        check("t2_valid_one_cycle", {63'd0, bus_if.valid_out}, 64'd0);

        // 3: max inputs saturate; zero operands.
        run_op("t3_max", 24'hFFFFFF, 26'h3FFFFFF, 24'hFFFFFF, 1'b1);
        run_op("zero_factor", 24'h123456, 26'h0, 24'd0, 1'b0);
        run_op("zero_operand", 24'd0, 26'h3FFFFFF, 24'd0, 1'b0);
        run_op("unity", 24'h00ABCD, 26'h2000000, 24'h00ABCD, 1'b0);
        run_op("x1p75", 24'd400, 26'h3800000, 24'd700, 1'b0);

        // 4: back-pressure in DONE; a valid_in pulse there is ignored.
        start_op(24'd300, 26'h2000000);
        wait_done(lat);
        held = bus_if.product_out;
        check("t4_product", 64'(held), 64'd300);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus_if.operand_in = 24'd77;
                bus_if.factor_in  = 26'h1000000;
                bus_if.valid_in   = 1'b1;
            end
            @(negedge clk);
            bus_if.valid_in = 1'b0;
            check("t4_valid_held", {63'd0, bus_if.valid_out}, 64'd1);
            check("t4_prod_held", 64'(bus_if.product_out), 64'(held));
            check("t4_ready_low", {63'd0, bus_if.ready_out}, 64'd0);
        end
        finish_op();
        repeat (3) @(negedge clk);
        check("t4_no_start_ready", {63'd0, bus_if.ready_out}, 64'd1);
        check("t4_no_start_valid", {63'd0, bus_if.valid_out}, 64'd0);

        // 5: reset mid-BUSY, then a fresh operation.
        start_op(24'd5000, 26'h2000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", {63'd0, bus_if.ready_out}, 64'd1);
        check("t5_valid", {63'd0, bus_if.valid_out}, 64'd0);
        check("t5_ovf", {63'd0, bus_if.overflow_out}, 64'd0);
        check("t5_prod", 64'(bus_if.product_out), 64'd0);
        run_op("t5_fresh", 24'd7, 26'h3000000, 24'd10, 1'b0);

        // 6: divide then multiply back; floor model plus round-trip window.
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                a = 64'd3000;
                b = 64'd7000;
            end else begin
                b = 64'($urandom_range(2, 24'hFFFFFF));
                a = 64'($urandom_range(0, 32'(b - 1)));
            end
            q     = (a << 25) / b;
            model = (b * q) >> 25;
            start_op(b[23:0], q[25:0]);
            wait_done(lat);
            check("rt_model", 64'(bus_if.product_out), model);
            check("rt_overflow", {63'd0, bus_if.overflow_out}, 64'd0);
            lo = (a == 0) ? 64'd0 : a - 1;
            check("rt_window",
                  {63'd0, (64'(bus_if.product_out) == a) || (64'(bus_if.product_out) == lo)},
                  64'd1);
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
